// File: rtl/scndbl_saver_pkg.sv
// Shared constants and FSM encoding for the scandoubler-setting write-back block.
package scndbl_saver_pkg;

    // SRAM byte address the memory block reads the setting from at power-up.
    localparam logic [20:0] ADDR_DEFAULT = 21'h08FD5;

    // Bit positions inside the two-bit setting.
    localparam int unsigned SCN_VGA   = 0;
    localparam int unsigned SCN_LINES = 1;

    typedef enum logic [2:0] {
        StIdle,
        StPend,
        StSetup,
        StWrite,
        StHold
    } state_e;

endpackage

// File: rtl/scndbl_saver_edge_rise.sv
// Single-bit rising-edge detector; while rearm_i is high no edge is reported and the
// history tracks the level, so a key already held when re-armed does not fire later.
module scndbl_saver_edge_rise (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    input  logic rearm_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-level register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    // Edge decode, suppressed while re-arming.
    always_comb begin
        rise_o = level_i & ~prev_q & ~rearm_i;
    end

endmodule

// File: rtl/scndbl_saver.sv
// Holds the live scandoubler setting, applies hotkey toggles and writes the byte back
// to SRAM, owning the bus only inside Z80 refresh cycles.
module scndbl_saver
    import scndbl_saver_pkg::*;
#(
    parameter int unsigned    AW    = 21,
    parameter logic [AW-1:0]  ADDR  = AW'(ADDR_DEFAULT),
    parameter int unsigned    SETUP = 2,
    parameter int unsigned    PULSE = 4,
    parameter int unsigned    HOLD  = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          power,
    input  logic [1:0]    scndblIn,
    input  logic          keyVga,
    input  logic          keyScan,
    input  logic          mreq,
    input  logic          rfsh,
    output logic [1:0]    scndbl,
    output logic          own,
    output logic          sramWe,
    output logic [7:0]    sramD,
    output logic [AW-1:0] sramA,
    output logic          busy
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] set_q, set_d;
    logic [1:0] snap_q, snap_d;
    logic       dirty_q, dirty_d;
    logic       win_q;
    logic       own_q, own_d;
    logic       we_q, we_d;

    logic       vga_rise, scan_rise;
    logic [1:0] tog;
    logic       win_now, win_open;

    scndbl_saver_edge_rise u_edge_vga (
        .clock   (clock),
        .reset   (reset),
        .level_i (keyVga),
        .rearm_i (~power),
        .rise_o  (vga_rise)
    );

    scndbl_saver_edge_rise u_edge_scan (
        .clock   (clock),
        .reset   (reset),
        .level_i (keyScan),
        .rearm_i (~power),
        .rise_o  (scan_rise)
    );

    // Toggle mask and refresh-window decode.
    always_comb begin
        tog            = 2'b00;
        tog[SCN_VGA]   = vga_rise;
        tog[SCN_LINES] = scan_rise;
        win_now        = ~rfsh & ~mreq;
        win_open       = win_now & ~win_q;
    end

    // Next-state logic for the setting, dirty flag, write FSM and registered bus outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        set_d   = set_q ^ tog;
        dirty_d = dirty_q | (|tog);

        unique case (state_q)
            StIdle: begin
                if (dirty_q) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (win_open) begin
                    snap_d  = set_q;
                    // A toggle landing on the latch cycle must still trigger a rewrite.
                    dirty_d = |tog;
                    cnt_d   = 8'(SETUP - 1);
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (!win_now) begin
                    dirty_d = 1'b1;
                    state_d = StPend;
                end else if (cnt_q == 8'd0) begin
                    cnt_d   = 8'(PULSE - 1);
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StWrite: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = 8'(HOLD - 1);
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    state_d = dirty_d ? StPend : StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Load phase: take the stored setting and discard any write in flight.
        if (!power) begin
            set_d   = scndblIn;
            dirty_d = 1'b0;
            cnt_d   = 8'd0;
            state_d = StIdle;
        end

        own_d = (state_d == StSetup) || (state_d == StWrite) || (state_d == StHold);
        we_d  = (state_d != StWrite);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            set_q   <= 2'b00;
            snap_q  <= 2'b00;
            dirty_q <= 1'b0;
            win_q   <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            snap_q  <= snap_d;
            dirty_q <= dirty_d;
            win_q   <= win_now;
            own_q   <= own_d;
            we_q    <= we_d;
        end
    end

    // Output wiring; sramD comes straight from the snapshot register.
    always_comb begin
        scndbl = set_q;
        own    = own_q;
        sramWe = we_q;
        sramD  = {6'b000000, snap_q};
        sramA  = ADDR;
        busy   = dirty_q | (state_q != StIdle);
    end

endmodule

// File: tb/tb_scndbl_saver.sv
// Randomised and directed bench for scndbl_saver with a behavioural setting model and a
// bus-protocol monitor that collects every completed SRAM write.
module tb_scndbl_saver;

    localparam int unsigned AW    = 21;
    localparam int unsigned SETUP = 2;
    localparam int unsigned PULSE = 4;
    localparam int unsigned HOLD  = 2;
    localparam logic [20:0] ADDR  = 21'h08FD5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          power = 1'b0;
    logic [1:0]    scndblIn = 2'b00;
    logic          keyVga = 1'b0;
    logic          keyScan = 1'b0;
    logic          mreq = 1'b1;
    logic          rfsh = 1'b1;
    logic [1:0]    scndbl;
    logic          own;
    logic          sramWe;
    logic [7:0]    sramD;
    logic [AW-1:0] sramA;
    logic          busy;

    scndbl_saver #(
        .AW    (AW),
        .ADDR  (ADDR),
        .SETUP (SETUP),
        .PULSE (PULSE),
        .HOLD  (HOLD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .power    (power),
        .scndblIn (scndblIn),
        .keyVga   (keyVga),
        .keyScan  (keyScan),
        .mreq     (mreq),
        .rfsh     (rfsh),
        .scndbl   (scndbl),
        .own      (own),
        .sramWe   (sramWe),
        .sramD    (sramD),
        .sramA    (sramA),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: live setting as the user sees it, plus monitor bookkeeping.
    logic [1:0] model_set  = 2'b00;
    logic [1:0] model_last = 2'b00;
    logic [7:0] writes[$];
    int         aborts     = 0;
    int         power_cuts = 0;

    int         cyc = 0;
    int         own_rise_cyc = 0;
    int         we_fall_cyc = 0;
    int         we_rise_cyc = 0;
    bit         in_pulse = 1'b0;
    bit         pulse_done = 1'b0;
    logic       own_p = 1'b0;
    logic       we_p = 1'b1;
    logic [7:0] pulse_d = 8'h00;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Keys toggle their setting bit on a 0->1 transition while power is high.
    task automatic drive_keys(input logic v, input logic s);
        if (power) begin
            if (v && !keyVga)  model_set[0] = ~model_set[0];
            if (s && !keyScan) model_set[1] = ~model_set[1];
        end
        keyVga  = v;
        keyScan = s;
    endtask

    task automatic set_power(input logic p, input logic [1:0] d);
        power    = p;
        scndblIn = d;
        if (!p) model_set = d;
    endtask

    task automatic window(input int len);
        rfsh = 1'b0;
        mreq = 1'b0;
        repeat (len) step();
        rfsh = 1'b1;
        mreq = 1'b1;
        step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            step();
        end
        check_eq("wait_idle_busy", int'(busy), 0);
    endtask

    // Bus monitor: checks phase lengths and the snapshot, records completed writes.
    always @(negedge clock) begin
        cyc++;
        check_eq("scndbl", int'(scndbl), int'(model_set));
        if (own && !own_p) begin
            own_rise_cyc = cyc;
            pulse_done   = 1'b0;
            in_pulse     = 1'b0;
            check_eq("snap_at_own", int'(sramD), int'({6'b0, model_last}));
            check_eq("sramA", int'(sramA), int'(ADDR));
        end
        if (!sramWe && we_p) begin
            check_eq("setup_len", cyc - own_rise_cyc, SETUP);
            check_eq("own_at_we_fall", int'(own), 1);
            we_fall_cyc = cyc;
            pulse_d     = sramD;
            in_pulse    = 1'b1;
        end
        if (in_pulse) check_eq("sramD_stable", int'(sramD), int'(pulse_d));
        if (sramWe && !we_p && own) begin
            check_eq("pulse_len", cyc - we_fall_cyc, PULSE);
            in_pulse    = 1'b0;
            pulse_done  = 1'b1;
            we_rise_cyc = cyc;
        end
        if (!own && own_p) begin
            if (in_pulse) begin
                check_eq("cut_we_high", int'(sramWe), 1);
                check_eq("cut_power_low", int'(power), 0);
                power_cuts++;
                in_pulse = 1'b0;
            end else if (pulse_done) begin
                check_eq("hold_len", cyc - we_rise_cyc, HOLD);
                writes.push_back(sramD);
                pulse_done = 1'b0;
            end else begin
                aborts++;
            end
        end
        own_p      = own;
        we_p       = sramWe;
        model_last = model_set;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int a0;
        int pc;

        // Reset values.
        repeat (3) step();
        check_eq("rst_own", int'(own), 0);
        check_eq("rst_we", int'(sramWe), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_scndbl", int'(scndbl), 0);
        check_eq("rst_sramD", int'(sramD), 0);
        reset = 1'b1;
        step();

        // Load 2'b10 during the power-low phase.
        set_power(1'b0, 2'b10);
        repeat (3) step();
        set_power(1'b1, 2'b10);
        repeat (2) step();
        check_eq("load_scndbl", int'(scndbl), 2);
        check_eq("load_busy", int'(busy), 0);
        check_eq("load_own", int'(own), 0);

        // VGA toggle and a full write of 8'h03.
        drive_keys(1'b1, 1'b0);
        step();
        check_eq("t1_scndbl", int'(scndbl), 3);
        check_eq("t1_busy", int'(busy), 1);
        repeat (3) step();
        n = writes.size();
        window(10);
        wait_idle();
        check_eq("t1_nwrites", writes.size(), n + 1);
        check_eq("t1_data", int'(writes[$]), 3);
        drive_keys(1'b0, 1'b0);
        step();

        // Window too short: abort, then retry on the next window.
        drive_keys(1'b0, 1'b1);
        repeat (3) step();
        a0 = aborts;
        n  = writes.size();
        window(1);
        repeat (4) step();
        check_eq("t2_abort", aborts, a0 + 1);
        check_eq("t2_no_write", writes.size(), n);
        check_eq("t2_busy", int'(busy), 1);
        window(10);
        wait_idle();
        check_eq("t2_nwrites", writes.size(), n + 1);
        check_eq("t2_data", int'(writes[$]), 1);
        drive_keys(1'b0, 1'b0);
        step();

        // Toggle during WRITE: old snapshot first, then a second write with the new value.
        drive_keys(1'b1, 1'b0);
        repeat (3) step();
        n    = writes.size();
        rfsh = 1'b0;
        mreq = 1'b0;
        repeat (3) step();
        drive_keys(1'b1, 1'b1);
        repeat (7) step();
        rfsh = 1'b1;
        mreq = 1'b1;
        repeat (3) step();
        window(10);
        wait_idle();
        check_eq("t3_nwrites", writes.size(), n + 2);
        if (writes.size() >= n + 2) begin
            check_eq("t3_first", int'(writes[n]), 0);
            check_eq("t3_second", int'(writes[n + 1]), 2);
        end

        // Simultaneous edges from 2'b00: one write of 8'h03.
        set_power(1'b0, 2'b00);
        repeat (2) step();
        set_power(1'b1, 2'b00);
        repeat (2) step();
        check_eq("t4_busy_cleared", int'(busy), 0);
        drive_keys(1'b0, 1'b0);
        step();
        n = writes.size();
        drive_keys(1'b1, 1'b1);
        step();
        check_eq("t4_scndbl", int'(scndbl), 3);
        repeat (2) step();
        window(10);
        wait_idle();
        check_eq("t4_nwrites", writes.size(), n + 1);
        check_eq("t4_data", int'(writes[$]), 3);

        // Power drops mid-WRITE: bus released next cycle, write discarded.
        drive_keys(1'b0, 1'b0);
        step();
        drive_keys(1'b1, 1'b0);
        repeat (3) step();
        n    = writes.size();
        pc   = power_cuts;
        rfsh = 1'b0;
        mreq = 1'b0;
        repeat (3) step();
        set_power(1'b0, 2'b01);
        step();
        check_eq("t5_own", int'(own), 0);
        check_eq("t5_we", int'(sramWe), 1);
        check_eq("t5_cut_seen", power_cuts, pc + 1);
        rfsh = 1'b1;
        mreq = 1'b1;
        repeat (2) step();
        set_power(1'b1, 2'b01);
        repeat (3) step();
        window(10);
        repeat (12) step();
        check_eq("t5_no_write", writes.size(), n);
        check_eq("t5_busy", int'(busy), 0);
        check_eq("t5_scndbl", int'(scndbl), 1);

        // Random key activity against random refresh windows.
        for (int w = 0; w < 40; w++) begin
            int gap;
            int len;
            gap = int'($urandom_range(2, 6));
            len = ($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(9, 12));
            rfsh = 1'b1;
            for (int g = 0; g < gap; g++) begin
                mreq = 1'($urandom % 2);
                drive_keys(keyVga ^ ($urandom % 6 == 0), keyScan ^ ($urandom % 6 == 0));
                step();
            end
            rfsh = 1'b0;
            mreq = 1'b0;
            for (int l = 0; l < len; l++) begin
                drive_keys(keyVga ^ ($urandom % 6 == 0), keyScan ^ ($urandom % 6 == 0));
                step();
            end
        end
        rfsh = 1'b1;
        mreq = 1'b1;
        step();

        // Drain: with keys quiet the last write must carry the final setting.
        for (int k = 0; k < 8 && busy; k++) begin
            repeat (3) step();
            window(10);
        end
        wait_idle();
        check_eq("rnd_any_write", int'(writes.size() > 0), 1);
        if (writes.size() > 0) check_eq("rnd_final_data", int'(writes[$]), int'(model_set));
        check_eq("rnd_own_idle", int'(own), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
